// File: rtl/palette_pkg.sv
// Shared palette constants: named colour indices, default RGB values and the
// reset-table helper used by the lookup and by anything modelling it.
package palette_pkg;

  localparam int unsigned IDX_W_DEF = 4;
  localparam int unsigned RGB_W_DEF = 12;

  localparam int unsigned C_TRANSP = 0;
  localparam int unsigned C_RED    = 1;
  localparam int unsigned C_DKRED  = 2;
  localparam int unsigned C_YELLOW = 3;
  localparam int unsigned C_BLACK  = 4;
  localparam int unsigned C_GREY   = 5;
  localparam int unsigned C_GREEN  = 6;
  localparam int unsigned C_OCHRE  = 7;
  localparam int unsigned C_WHITE  = 8;
  localparam int unsigned C_LIME   = 9;
  localparam int unsigned C_LTGREY = 10;

  localparam logic [11:0] RGB_TRANSP     = 12'h000;
  localparam logic [11:0] RGB_RED        = 12'hD42;
  localparam logic [11:0] RGB_DKRED      = 12'h921;
  localparam logic [11:0] RGB_YELLOW     = 12'hFF9;
  localparam logic [11:0] RGB_BLACK      = 12'h210;
  localparam logic [11:0] RGB_GREY       = 12'h778;
  localparam logic [11:0] RGB_GREEN      = 12'h6B4;
  localparam logic [11:0] RGB_OCHRE      = 12'hDD0;
  localparam logic [11:0] RGB_WHITE      = 12'hFFF;
  localparam logic [11:0] RGB_LIME       = 12'h0F0;
  localparam logic [11:0] RGB_LTGREY     = 12'hBBB;
  localparam logic [11:0] RGB_ERROR      = 12'hF0F;
  localparam logic [11:0] RGB_TINT_RED   = 12'h8DF;
  localparam logic [11:0] RGB_TINT_DKRED = 12'h009;

  // 12-bit reset colour; every bank above 0 carries the alternate player tint.
  function automatic logic [11:0] default_rgb(input int unsigned bank, input int unsigned idx);
    logic [11:0] rgb;
    case (idx)
      C_TRANSP: rgb = RGB_TRANSP;
      C_RED:    rgb = RGB_RED;
      C_DKRED:  rgb = RGB_DKRED;
      C_YELLOW: rgb = RGB_YELLOW;
      C_BLACK:  rgb = RGB_BLACK;
      C_GREY:   rgb = RGB_GREY;
      C_GREEN:  rgb = RGB_GREEN;
      C_OCHRE:  rgb = RGB_OCHRE;
      C_WHITE:  rgb = RGB_WHITE;
      C_LIME:   rgb = RGB_LIME;
      C_LTGREY: rgb = RGB_LTGREY;
      default:  rgb = RGB_ERROR;
    endcase
    if (bank != 0) begin
      if (idx == C_RED) rgb = RGB_TINT_RED;
      else if (idx == C_DKRED) rgb = RGB_TINT_DKRED;
    end
    return rgb;
  endfunction

  // Rescale a 4:4:4 colour per channel: truncate to the top bits, or pad zeros below.
  function automatic logic [47:0] scale_rgb(input logic [11:0] c, input int unsigned rgb_w);
    int unsigned cw;
    logic [47:0] res;
    logic [47:0] ch_v;
    cw  = rgb_w / 3;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      ch_v = 48'(c[ch*4 +: 4]);
      if (cw <= 4) ch_v = ch_v >> (4 - cw);
      else ch_v = ch_v << (cw - 4);
      res = res | (ch_v << (ch * cw));
    end
    return res;
  endfunction

endpackage

// File: rtl/flash_timer.sv
// Frame-synchronous hit-flash timer: counts frame ticks while enabled and
// toggles the flash phase every FLASH_FRAMES ticks.
module flash_timer #(
  parameter int unsigned FLASH_FRAMES = 4,
  localparam int unsigned CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flash_en,
  input  logic             i_frame_tick,
  output logic [CNT_W-1:0] o_count,
  output logic             o_phase
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FLASH_FRAMES - 1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_phase;
  logic             w_phase_nxt;

  always_comb begin
    w_count_nxt = r_count;
    w_phase_nxt = r_phase;
    if (!i_flash_en) begin
      w_count_nxt = '0;
      w_phase_nxt = 1'b0;
    end else if (i_frame_tick) begin
      if (r_count == LAST) begin
        w_count_nxt = '0;
        w_phase_nxt = ~r_phase;
      end else begin
        w_count_nxt = r_count + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
      r_phase <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  assign o_count = r_count;
  assign o_phase = r_phase;

endmodule

// File: rtl/palette_lut.sv
// Registered, runtime-programmable sprite palette: colour index + bank -> RGB,
// two-cycle latency, with an optional frame-synchronous hit flash.
module palette_lut
  import palette_pkg::*;
#(
  parameter int unsigned       IDX_W        = IDX_W_DEF,
  parameter int unsigned       NUM_BANKS    = 2,
  parameter int unsigned       RGB_W        = RGB_W_DEF,
  parameter int unsigned       TRANSP_IDX   = 0,
  parameter int unsigned       FLASH_FRAMES = 4,
  parameter logic [RGB_W-1:0]  FLASH_RGB    = RGB_W'(12'hFFF),
  localparam int unsigned      BANK_W       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [IDX_W-1:0]  in_index,
  input  logic [BANK_W-1:0] in_bank,
  output logic              out_valid,
  output logic [RGB_W-1:0]  out_rgb,
  output logic              out_opaque,
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [RGB_W-1:0]  wr_rgb,
  input  logic              flash_en,
  input  logic              frame_tick
);

  localparam int unsigned       NUM_IDX     = 2 ** IDX_W;
  localparam int unsigned       CNT_W       = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [IDX_W-1:0]  TRANSP      = IDX_W'(TRANSP_IDX);
  localparam logic [BANK_W:0]   NUM_BANKS_W = (BANK_W + 1)'(NUM_BANKS);

  // Flop array rather than RAM so reset can restore the default table.
  logic [RGB_W-1:0]  r_table [NUM_BANKS][NUM_IDX];

  logic [BANK_W-1:0] w_rd_bank;
  logic              w_wr_ok;
  logic [RGB_W-1:0]  w_s2_rgb;
  logic              w_flash_phase;
  logic [CNT_W-1:0]  w_flash_count;

  logic [RGB_W-1:0]  r_s1_rgb;
  logic              r_s1_opaque;
  logic              r_s1_valid;
  logic [RGB_W-1:0]  r_out_rgb;
  logic              r_out_opaque;
  logic              r_out_valid;

  always_comb begin
    w_rd_bank = ({1'b0, in_bank} < NUM_BANKS_W) ? in_bank : '0;
    w_wr_ok   = wr_en && ({1'b0, wr_bank} < NUM_BANKS_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int i = 0; i < NUM_IDX; i++) begin
          r_table[b][i] <= RGB_W'(scale_rgb(default_rgb(b, i), RGB_W));
        end
      end
    end else if (w_wr_ok) begin
      r_table[wr_bank][wr_index] <= wr_rgb;
    end
  end

  always_comb begin
    w_s2_rgb = r_s1_rgb;
    if (!r_s1_opaque) w_s2_rgb = '0;
    else if (flash_en && w_flash_phase) w_s2_rgb = FLASH_RGB;
  end

  // Stage 1 reads the table before any same-edge write lands (read-before-write).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_rgb     <= '0;
      r_s1_opaque  <= 1'b0;
      r_s1_valid   <= 1'b0;
      r_out_rgb    <= '0;
      r_out_opaque <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      r_s1_rgb     <= r_table[w_rd_bank][in_index];
      r_s1_opaque  <= (in_index != TRANSP);
      r_s1_valid   <= in_valid;
      r_out_rgb    <= w_s2_rgb;
      r_out_opaque <= r_s1_opaque;
      r_out_valid  <= r_s1_valid;
    end
  end

  flash_timer #(
    .FLASH_FRAMES(FLASH_FRAMES)
  ) u_flash (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flash_en  (flash_en),
    .i_frame_tick(frame_tick),
    .o_count     (w_flash_count),
    .o_phase     (w_flash_phase)
  );

  assign out_valid  = r_out_valid;
  assign out_rgb    = r_out_rgb;
  assign out_opaque = r_out_opaque;

endmodule

// File: tb/tb_palette_lut.sv
// Directed plus randomized bench for palette_lut (3 banks to exercise the
// out-of-range bank path) against a cycle-level reference model.
module tb_palette_lut;
  import palette_pkg::*;

  localparam int unsigned IDX_W        = 4;
  localparam int unsigned NUM_BANKS    = 3;
  localparam int unsigned RGB_W        = 12;
  localparam int unsigned TRANSP_IDX   = 0;
  localparam int unsigned FLASH_FRAMES = 4;
  localparam logic [11:0] FLASH_RGB    = 12'hFFF;
  localparam int unsigned BANK_W       = 2;
  localparam int unsigned N_IDX        = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [IDX_W-1:0]  in_index;
  logic [BANK_W-1:0] in_bank;
  logic              out_valid;
  logic [RGB_W-1:0]  out_rgb;
  logic              out_opaque;
  logic              wr_en;
  logic [BANK_W-1:0] wr_bank;
  logic [IDX_W-1:0]  wr_index;
  logic [RGB_W-1:0]  wr_rgb;
  logic              flash_en;
  logic              frame_tick;

  always #5 clk = ~clk;

  palette_lut #(
    .IDX_W       (IDX_W),
    .NUM_BANKS   (NUM_BANKS),
    .RGB_W       (RGB_W),
    .TRANSP_IDX  (TRANSP_IDX),
    .FLASH_FRAMES(FLASH_FRAMES),
    .FLASH_RGB   (FLASH_RGB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_index  (in_index),
    .in_bank   (in_bank),
    .out_valid (out_valid),
    .out_rgb   (out_rgb),
    .out_opaque(out_opaque),
    .wr_en     (wr_en),
    .wr_bank   (wr_bank),
    .wr_index  (wr_index),
    .wr_rgb    (wr_rgb),
    .flash_en  (flash_en),
    .frame_tick(frame_tick)
  );

  // Reference model: palette contents, ticks seen since flash enable, and the
  // one lookup result still waiting to emerge.
  logic [11:0] m_tab [NUM_BANKS][N_IDX];
  int          m_ticks;
  logic        p_valid, p_opaque;
  logic [11:0] p_rgb;
  logic        e_valid, e_opaque;
  logic [11:0] e_rgb;

  logic [11:0] exp_b0 [N_IDX] = '{12'h000, 12'hD42, 12'h921, 12'hFF9, 12'h210, 12'h778,
                                  12'h6B4, 12'hDD0, 12'hFFF, 12'h0F0, 12'hBBB, 12'hF0F,
                                  12'hF0F, 12'hF0F, 12'hF0F, 12'hF0F};
  logic [11:0] exp_oob [4] = '{12'hD42, 12'h8DF, 12'h8DF, 12'hD42};
  logic        gap_pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  int n_vec = 0;
  int n_err = 0;

  task automatic model_edge();
    bit phase;
    int bsel;
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++)
        for (int i = 0; i < N_IDX; i++) m_tab[b][i] = default_rgb(b, i);
      m_ticks = 0;
      p_valid = 0; p_opaque = 0; p_rgb = '0;
      e_valid = 0; e_opaque = 0; e_rgb = '0;
      return;
    end
    phase    = ((m_ticks / FLASH_FRAMES) % 2) == 1;
    e_valid  = p_valid;
    e_opaque = p_opaque;
    e_rgb    = !p_opaque ? 12'h000 : (flash_en && phase) ? FLASH_RGB : p_rgb;
    bsel     = (int'(in_bank) < NUM_BANKS) ? int'(in_bank) : 0;
    p_valid  = in_valid;
    p_opaque = (int'(in_index) != TRANSP_IDX);
    p_rgb    = m_tab[bsel][in_index];
    if (wr_en && int'(wr_bank) < NUM_BANKS) m_tab[wr_bank][wr_index] = wr_rgb;
    if (!flash_en) m_ticks = 0;
    else if (frame_tick) m_ticks++;
  endtask

  // One clock: advance the model at the edge, then sample the DUT 1 ns later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    n_vec++;
    assert (out_valid === e_valid) else begin
      n_err++;
      $error("FAIL model_valid obs=%0b exp=%0b t=%0t", out_valid, e_valid, $time);
    end
    if (e_valid) begin
      n_vec++;
      assert (out_rgb === e_rgb) else begin
        n_err++;
        $error("FAIL model_rgb obs=%03h exp=%03h t=%0t", out_rgb, e_rgb, $time);
      end
      n_vec++;
      assert (out_opaque === e_opaque) else begin
        n_err++;
        $error("FAIL model_opaque obs=%0b exp=%0b t=%0t", out_opaque, e_opaque, $time);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%03h exp=%03h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input int bank, input int idx);
    in_valid = v;
    in_bank  = BANK_W'(bank);
    in_index = IDX_W'(idx);
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    wr_en      = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_index = '0; in_bank = '0;
    wr_en = 0; wr_bank = '0; wr_index = '0; wr_rgb = '0;
    flash_en = 0; frame_tick = 0;

    // Reset state
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_valid", 12'(out_valid), 12'h0);
    chk("rst_rgb", out_rgb, 12'h000);
    chk("rst_opaque", 12'(out_opaque), 12'h0);
    chk("rst_phase", 12'(dut.u_flash.o_phase), 12'h0);

    // Default table readback, bank 0
    for (int i = 0; i <= N_IDX; i++) begin
      if (i < N_IDX) drive(1'b1, 0, i);
      else idle();
      cyc();
      if (i >= 1) begin
        chk("dflt_rgb", out_rgb, exp_b0[i-1]);
        chk("dflt_opq", 12'(out_opaque), (i - 1 == 0) ? 12'h0 : 12'h1);
      end
    end
    drive(1'b1, 1, 1); cyc();
    drive(1'b1, 1, 2); cyc(); chk("b1_idx1", out_rgb, 12'h8DF);
    idle(); cyc(); chk("b1_idx2", out_rgb, 12'h009);

    // Same-cycle write/read hazard, then reset restores the default
    drive(1'b1, 0, 3);
    wr_en = 1'b1; wr_bank = 2'd0; wr_index = 4'd3; wr_rgb = 12'h0A5;
    cyc();
    wr_en = 1'b0;
    cyc(); chk("rbw_old", out_rgb, 12'hFF9);
    idle(); cyc(); chk("rbw_new", out_rgb, 12'h0A5);
    rst = 1'b1; cyc(); rst = 1'b0;
    drive(1'b1, 0, 3); cyc();
    idle(); cyc(); chk("rst_restore", out_rgb, 12'hFF9);

    // Valid gaps, full throughput
    for (int i = 0; i < 6; i++) begin
      drive(gap_pat[i], 0, 1 + (i % 9));
      cyc();
      if (i >= 1) chk("gap_valid", 12'(out_valid), 12'(gap_pat[i-1]));
    end

    // Flash
    idle(); flash_en = 1'b1; cyc();
    ticks(4);
    drive(1'b1, 0, 1); cyc();
    drive(1'b1, 0, 0); cyc(); chk("flash_on", out_rgb, 12'hFFF);
    idle(); cyc();
    chk("flash_transp", out_rgb, 12'h000);
    chk("flash_transp_opq", 12'(out_opaque), 12'h0);
    ticks(4);
    drive(1'b1, 0, 1); cyc();
    idle(); cyc(); chk("flash_off", out_rgb, 12'hD42);
    ticks(4);
    flash_en = 1'b0;
    drive(1'b1, 0, 1); cyc();
    idle(); cyc(); chk("flash_drop", out_rgb, 12'hD42);
    chk("flash_drop_phase", 12'(dut.u_flash.o_phase), 12'h0);

    // Out-of-range bank read and write
    drive(1'b1, 3, 1); cyc();
    idle();
    wr_en = 1'b1; wr_bank = 2'd3; wr_index = 4'd1; wr_rgb = 12'h123;
    cyc(); chk("oob_read", out_rgb, 12'hD42);
    wr_en = 1'b0;
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, j, 1); cyc();
      if (j > 0) chk("oob_write", out_rgb, exp_oob[j-1]);
    end
    idle(); cyc(); chk("oob_write", out_rgb, exp_oob[3]);

    // Reset with two pixels in flight and a running flash counter
    flash_en = 1'b1; frame_tick = 1'b1; cyc(); cyc(); frame_tick = 1'b0;
    drive(1'b1, 0, 5); cyc();
    drive(1'b1, 0, 6); cyc();
    rst = 1'b1; frame_tick = 1'b1; wr_en = 1'b1; wr_bank = 2'd0; wr_index = 4'd5;
    wr_rgb = 12'hABC; drive(1'b1, 0, 7); cyc();
    rst = 1'b0; idle();
    chk("midrst_valid0", 12'(out_valid), 12'h0);
    chk("midrst_count", 12'(dut.u_flash.o_count), 12'h0);
    chk("midrst_phase", 12'(dut.u_flash.o_phase), 12'h0);
    drive(1'b1, 0, 5); cyc();
    chk("midrst_valid1", 12'(out_valid), 12'h0);
    idle(); cyc(); chk("midrst_wr_blocked", out_rgb, 12'h778);
    flash_en = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(63) == 0);
      in_valid   = $urandom_range(1);
      in_index   = IDX_W'($urandom_range(N_IDX - 1));
      in_bank    = BANK_W'($urandom_range(3));
      wr_en      = ($urandom_range(3) == 0);
      wr_bank    = BANK_W'($urandom_range(3));
      wr_index   = IDX_W'($urandom_range(N_IDX - 1));
      wr_rgb     = RGB_W'($urandom);
      frame_tick = ($urandom_range(3) == 0);
      if ($urandom_range(31) == 0) flash_en = ~flash_en;
      cyc();
    end
    rst = 1'b0; idle(); cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
